// File: rtl/bd_tag_router_if.sv
// Bundle of input, output-stream, config and counter signals for bd_tag_router.
// master drives words and consumer accepts; slave is the router itself.
interface bd_tag_router_if #(
    parameter int unsigned NBDdata = 34,
    parameter int unsigned Nleaf   = 5,
    parameter int unsigned Nglobal = 12,
    parameter int unsigned Ntag    = 11,
    parameter int unsigned Nct     = 9,
    parameter int unsigned Ncnt    = 16
);
    logic               in_v;
    logic [Nleaf-1:0]   in_leaf_code;
    logic [NBDdata-1:0] in_payload;
    logic               in_a;

    logic               tag_v;
    logic [Ntag-1:0]    tag_tag;
    logic [Nct-1:0]     tag_ct;
    logic               tag_a;

    logic               gtag_v;
    logic [Nglobal-1:0] gtag_global_tag;
    logic [Ntag-1:0]    gtag_tag;
    logic [Nct-1:0]     gtag_ct;
    logic               gtag_a;

    logic               other_v;
    logic [Nleaf-1:0]   other_leaf_code;
    logic [NBDdata-1:0] other_payload;
    logic               other_a;

    logic               conf_report_tags;
    logic               conf_global_en;
    logic               cnt_clear;
    logic [Ncnt-1:0]    cnt_local;
    logic [Ncnt-1:0]    cnt_global;
    logic [Ncnt-1:0]    cnt_other;

    modport master (
        output in_v, in_leaf_code, in_payload, tag_a, gtag_a, other_a,
               conf_report_tags, conf_global_en, cnt_clear,
        input  in_a, tag_v, tag_tag, tag_ct, gtag_v, gtag_global_tag, gtag_tag, gtag_ct,
               other_v, other_leaf_code, other_payload, cnt_local, cnt_global, cnt_other
    );

    modport slave (
        input  in_v, in_leaf_code, in_payload, tag_a, gtag_a, other_a,
               conf_report_tags, conf_global_en, cnt_clear,
        output in_a, tag_v, tag_tag, tag_ct, gtag_v, gtag_global_tag, gtag_tag, gtag_ct,
               other_v, other_leaf_code, other_payload, cnt_local, cnt_global, cnt_other
    );
endinterface

// File: rtl/bd_tag_router.sv
// Classifies BD words into local-tag, global-tag and other streams, each behind its own
// FIFO; a word is written to all of its destinations on one edge or not at all.
module bd_tag_router #(
    parameter int unsigned NBDdata     = 34,
    parameter int unsigned Nleaf       = 5,
    parameter int unsigned Nglobal     = 12,
    parameter int unsigned Ntag        = 11,
    parameter int unsigned Nct         = 9,
    parameter int unsigned RO_ACC_CODE = 11,
    parameter int unsigned RO_TAT_CODE = 12,
    parameter int unsigned HOME_GT     = 0,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned Ncnt        = 16
) (
    input logic            clk,
    input logic            reset,
    bd_tag_router_if.slave bus
);
    localparam int unsigned TW   = Ntag + Nct;
    localparam int unsigned GW   = Nglobal + Ntag + Nct;
    localparam int unsigned OW   = Nleaf + NBDdata;
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [Nct-1:0]     w_ct;
    logic [Ntag-1:0]    w_tag;
    logic [Nglobal-1:0] w_gt;
    logic               w_is_tag, w_to_g, w_to_t, w_to_o;
    logic               w_in_a, w_accept;

    logic [TW-1:0]   r_t_mem [DEPTH];
    logic [PtrW-1:0] r_t_wptr, r_t_rptr;
    logic [CntW-1:0] r_t_cnt;
    logic            w_t_full, w_t_push, w_t_pop;

    logic [GW-1:0]   r_g_mem [DEPTH];
    logic [PtrW-1:0] r_g_wptr, r_g_rptr;
    logic [CntW-1:0] r_g_cnt;
    logic            w_g_full, w_g_push, w_g_pop;

    logic [OW-1:0]   r_o_mem [DEPTH];
    logic [PtrW-1:0] r_o_wptr, r_o_rptr;
    logic [CntW-1:0] r_o_cnt;
    logic            w_o_full, w_o_push, w_o_pop;

    logic [Ncnt-1:0] r_cnt_local, r_cnt_global, r_cnt_other;

    assign w_ct  = bus.in_payload[Nct-1:0];
    assign w_tag = bus.in_payload[TW-1:Nct];
    assign w_gt  = bus.in_payload[GW-1:TW];

    assign w_is_tag = (bus.in_leaf_code == Nleaf'(RO_ACC_CODE)) ||
                      (bus.in_leaf_code == Nleaf'(RO_TAT_CODE));
    assign w_to_g   = w_is_tag & bus.conf_global_en & (w_gt != Nglobal'(HOME_GT));
    assign w_to_t   = w_is_tag & ~w_to_g;
    assign w_to_o   = ~w_is_tag | (w_to_t & bus.conf_report_tags);

    assign w_t_full = (r_t_cnt == FullCnt);
    assign w_g_full = (r_g_cnt == FullCnt);
    assign w_o_full = (r_o_cnt == FullCnt);

    // Registered fullness only, so consumer accepts never reach in_a combinationally.
    assign w_in_a   = (~w_to_t | ~w_t_full) & (~w_to_g | ~w_g_full) & (~w_to_o | ~w_o_full);
    assign w_accept = bus.in_v & w_in_a;
    assign bus.in_a = w_in_a;

    assign w_t_push = w_accept & w_to_t;
    assign w_g_push = w_accept & w_to_g;
    assign w_o_push = w_accept & w_to_o;

    assign w_t_pop = (r_t_cnt != '0) & bus.tag_a;
    assign w_g_pop = (r_g_cnt != '0) & bus.gtag_a;
    assign w_o_pop = (r_o_cnt != '0) & bus.other_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_t_mem[i] <= '0;
            r_t_wptr <= '0;
            r_t_rptr <= '0;
            r_t_cnt  <= '0;
        end else begin
            if (w_t_push) begin
                r_t_mem[r_t_wptr] <= {w_tag, w_ct};
                r_t_wptr          <= r_t_wptr + PtrW'(1);
            end
            if (w_t_pop) r_t_rptr <= r_t_rptr + PtrW'(1);
            if (w_t_push && !w_t_pop) r_t_cnt <= r_t_cnt + CntW'(1);
            else if (!w_t_push && w_t_pop) r_t_cnt <= r_t_cnt - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_g_mem[i] <= '0;
            r_g_wptr <= '0;
            r_g_rptr <= '0;
            r_g_cnt  <= '0;
        end else begin
            if (w_g_push) begin
                r_g_mem[r_g_wptr] <= {w_gt, w_tag, w_ct};
                r_g_wptr          <= r_g_wptr + PtrW'(1);
            end
            if (w_g_pop) r_g_rptr <= r_g_rptr + PtrW'(1);
            if (w_g_push && !w_g_pop) r_g_cnt <= r_g_cnt + CntW'(1);
            else if (!w_g_push && w_g_pop) r_g_cnt <= r_g_cnt - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_o_mem[i] <= '0;
            r_o_wptr <= '0;
            r_o_rptr <= '0;
            r_o_cnt  <= '0;
        end else begin
            if (w_o_push) begin
                r_o_mem[r_o_wptr] <= {bus.in_leaf_code, bus.in_payload};
                r_o_wptr          <= r_o_wptr + PtrW'(1);
            end
            if (w_o_pop) r_o_rptr <= r_o_rptr + PtrW'(1);
            if (w_o_push && !w_o_pop) r_o_cnt <= r_o_cnt + CntW'(1);
            else if (!w_o_push && w_o_pop) r_o_cnt <= r_o_cnt - CntW'(1);
        end
    end

    // Clear has priority over a same-edge push; counts stick at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt_local  <= '0;
            r_cnt_global <= '0;
            r_cnt_other  <= '0;
        end else if (bus.cnt_clear) begin
            r_cnt_local  <= '0;
            r_cnt_global <= '0;
            r_cnt_other  <= '0;
        end else begin
            if (w_t_push && (r_cnt_local != '1))  r_cnt_local  <= r_cnt_local + Ncnt'(1);
            if (w_g_push && (r_cnt_global != '1)) r_cnt_global <= r_cnt_global + Ncnt'(1);
            if (w_o_push && (r_cnt_other != '1))  r_cnt_other  <= r_cnt_other + Ncnt'(1);
        end
    end

    assign bus.tag_v                    = (r_t_cnt != '0);
    assign {bus.tag_tag, bus.tag_ct}    = r_t_mem[r_t_rptr];
    assign bus.gtag_v                   = (r_g_cnt != '0);
    assign {bus.gtag_global_tag, bus.gtag_tag, bus.gtag_ct} = r_g_mem[r_g_rptr];
    assign bus.other_v                  = (r_o_cnt != '0);
    assign {bus.other_leaf_code, bus.other_payload}         = r_o_mem[r_o_rptr];

    assign bus.cnt_local  = r_cnt_local;
    assign bus.cnt_global = r_cnt_global;
    assign bus.cnt_other  = r_cnt_other;
endmodule

// File: tb/tb_bd_tag_router.sv
// Self-checking bench for bd_tag_router: classification table, scoreboarded streams,
// backpressure, stall isolation, counter saturation/clear and mid-stream reset.
module tb_bd_tag_router;
    localparam int unsigned NCNT   = 4;
    localparam int unsigned CNTMAX = (1 << NCNT) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bd_tag_router_if #(.Ncnt(NCNT)) bus ();

    bd_tag_router #(.Ncnt(NCNT)) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [4:0]  leaf;
        logic [33:0] pl;
        logic        rep;
        logic        gen;
        logic        et;
        logic        eg;
        logic        eo;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [63:0] q_t[$];
    logic [63:0] q_g[$];
    logic [63:0] q_o[$];
    int unsigned m_loc, m_glb, m_oth;
    logic [63:0] m_exp;
    logic [11:0] m_gt;
    logic        m_is_tag, m_tg, m_tt, m_to;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] mk(input logic [11:0] gt, input logic [10:0] tg,
                                       input logic [8:0] ct);
        return {2'b00, gt, tg, ct};
    endfunction

    // Scoreboard: predictions pushed on input transfers, compared on output transfers.
    always @(negedge clk) begin
        if (!reset) begin
            q_t.delete();
            q_g.delete();
            q_o.delete();
            m_loc = 0;
            m_glb = 0;
            m_oth = 0;
        end else begin
            if (bus.tag_v && bus.tag_a) begin
                if (q_t.size() == 0) check("tag_unexpected", 64'd1, 64'd0);
                else begin
                    m_exp = q_t.pop_front();
                    check("tag_data", 64'({bus.tag_tag, bus.tag_ct}), m_exp);
                end
            end
            if (bus.gtag_v && bus.gtag_a) begin
                if (q_g.size() == 0) check("gtag_unexpected", 64'd1, 64'd0);
                else begin
                    m_exp = q_g.pop_front();
                    check("gtag_data",
                          64'({bus.gtag_global_tag, bus.gtag_tag, bus.gtag_ct}), m_exp);
                end
            end
            if (bus.other_v && bus.other_a) begin
                if (q_o.size() == 0) check("other_unexpected", 64'd1, 64'd0);
                else begin
                    m_exp = q_o.pop_front();
                    check("other_data", 64'({bus.other_leaf_code, bus.other_payload}), m_exp);
                end
            end
            m_gt     = bus.in_payload[31:20];
            m_is_tag = (bus.in_leaf_code == 5'd11) || (bus.in_leaf_code == 5'd12);
            m_tg     = m_is_tag && bus.conf_global_en && (m_gt != 12'd0);
            m_tt     = m_is_tag && !m_tg;
            m_to     = !m_is_tag || (m_tt && bus.conf_report_tags);
            if (bus.in_v && bus.in_a) begin
                if (m_tt) q_t.push_back(64'(bus.in_payload[19:0]));
                if (m_tg) q_g.push_back(64'(bus.in_payload[31:0]));
                if (m_to) q_o.push_back(64'({bus.in_leaf_code, bus.in_payload}));
            end
            if (bus.cnt_clear) begin
                m_loc = 0;
                m_glb = 0;
                m_oth = 0;
            end else if (bus.in_v && bus.in_a) begin
                if (m_tt && m_loc != CNTMAX) m_loc++;
                if (m_tg && m_glb != CNTMAX) m_glb++;
                if (m_to && m_oth != CNTMAX) m_oth++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] leaf, input logic [33:0] pl);
        bit acc = 1'b0;
        bus.in_leaf_code = leaf;
        bus.in_payload   = pl;
        bus.in_v         = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.in_a) begin
                acc = 1'b1;
                break;
            end
            tick();
        end
        if (acc) tick();
        else check("accept_timeout", 64'd0, 64'd1);
        bus.in_v = 1'b0;
    endtask

    task automatic check_cnts();
        check("cnt_local", 64'(bus.cnt_local), 64'(m_loc));
        check("cnt_global", 64'(bus.cnt_global), 64'(m_glb));
        check("cnt_other", 64'(bus.cnt_other), 64'(m_oth));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        bit   acc;
        vecs[0] = '{5'd11, mk(12'h000, 11'h155, 9'h0AA), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{5'd11, mk(12'h000, 11'h155, 9'h0AA), 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{5'd12, mk(12'h3A5, 11'h012, 9'h034), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{5'd12, mk(12'h3A5, 11'h012, 9'h034), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{5'd12, mk(12'h3A5, 11'h7FF, 9'h1FF), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{5'd3,  34'h2DEADBEEF,                 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{5'd11, mk(12'h3A5, 11'h001, 9'h002), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{5'd0,  34'h123456789,                 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b0;
        bus.in_v = 1'b0;
        bus.in_leaf_code = '0;
        bus.in_payload = '0;
        bus.tag_a = 1'b1;
        bus.gtag_a = 1'b1;
        bus.other_a = 1'b1;
        bus.conf_report_tags = 1'b0;
        bus.conf_global_en = 1'b1;
        bus.cnt_clear = 1'b0;
        #12;
        check("rst_in_a", 64'(bus.in_a), 64'd1);
        check("rst_tag_v", 64'(bus.tag_v), 64'd0);
        check("rst_gtag_v", 64'(bus.gtag_v), 64'd0);
        check("rst_other_v", 64'(bus.other_v), 64'd0);
        check("rst_tag_data", 64'({bus.tag_tag, bus.tag_ct}), 64'd0);
        check("rst_gtag_gt", 64'(bus.gtag_global_tag), 64'd0);
        check("rst_other_pl", 64'(bus.other_payload), 64'd0);
        check("rst_cnt_local", 64'(bus.cnt_local), 64'd0);
        #1 reset = 1'b1;
        tick();

        // Classification table with all consumers ready.
        for (int i = 0; i < 8; i++) begin
            bus.conf_report_tags = vecs[i].rep;
            bus.conf_global_en   = vecs[i].gen;
            send(vecs[i].leaf, vecs[i].pl);
            @(negedge clk);
            check($sformatf("vec%0d_tag_v", i), 64'(bus.tag_v), 64'(vecs[i].et));
            check($sformatf("vec%0d_gtag_v", i), 64'(bus.gtag_v), 64'(vecs[i].eg));
            check($sformatf("vec%0d_other_v", i), 64'(bus.other_v), 64'(vecs[i].eo));
            if (vecs[i].et) check($sformatf("vec%0d_tag", i), 64'(bus.tag_tag),
                                  64'(vecs[i].pl[19:9]));
            if (vecs[i].eg) check($sformatf("vec%0d_gt", i), 64'(bus.gtag_global_tag),
                                  64'(vecs[i].pl[31:20]));
            tick();
            check_cnts();
            if (i == 0) check("vec0_cnt_local_one", 64'(bus.cnt_local), 64'd1);
        end

        // Reported local tags with other stream blocked: no lone tag copy may escape.
        bus.cnt_clear = 1'b1;
        tick();
        bus.cnt_clear = 1'b0;
        bus.conf_report_tags = 1'b1;
        bus.conf_global_en = 1'b1;
        bus.other_a = 1'b0;
        send(5'd11, mk(12'h000, 11'h155, 9'h0AA));
        send(5'd11, mk(12'h000, 11'h155, 9'h0AA));
        tick();
        bus.in_leaf_code = 5'd11;
        bus.in_payload = mk(12'h000, 11'h155, 9'h0AA);
        bus.in_v = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rep_stall_in_a", 64'(bus.in_a), 64'd0);
            check("rep_no_lone_tag", 64'(bus.tag_v), 64'd0);
            tick();
        end
        bus.other_a = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 10 && !acc; c++) begin
            @(negedge clk);
            acc = bus.in_a;
            tick();
        end
        bus.in_v = 1'b0;
        if (!acc) check("rep_accept_timeout", 64'd0, 64'd1);
        repeat (4) tick();
        check("rep_cnt_local", 64'(bus.cnt_local), 64'd3);
        check("rep_cnt_other", 64'(bus.cnt_other), 64'd3);
        check_cnts();

        // Global consumer stalled: only words needing gtag are held back.
        bus.conf_report_tags = 1'b0;
        bus.gtag_a = 1'b0;
        send(5'd12, mk(12'h101, 11'h001, 9'h001));
        send(5'd3,  34'h011111111);
        send(5'd12, mk(12'h102, 11'h002, 9'h002));
        send(5'd3,  34'h022222222);
        bus.in_leaf_code = 5'd12;
        bus.in_payload = mk(12'h103, 11'h003, 9'h003);
        bus.in_v = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("gstall_in_a", 64'(bus.in_a), 64'd0);
            check("gstall_head_hold", 64'(bus.gtag_global_tag), 64'h101);
            tick();
        end
        check("gstall_other_drained", 64'(bus.other_v), 64'd0);
        bus.in_v = 1'b0;
        send(5'd3, 34'h033333333);
        @(negedge clk);
        check("gstall_other_flows", 64'(bus.other_v), 64'd1);
        tick();
        bus.gtag_a = 1'b1;
        send(5'd12, mk(12'h103, 11'h003, 9'h003));
        repeat (3) tick();
        check_cnts();

        // Counter saturation, then clear winning over a same-edge push.
        bus.cnt_clear = 1'b1;
        tick();
        bus.cnt_clear = 1'b0;
        for (int i = 0; i < 20; i++) send(5'd11, mk(12'h000, 11'(i), 9'(i)));
        tick();
        check("sat_cnt_local", 64'(bus.cnt_local), 64'(CNTMAX));
        check_cnts();
        bus.cnt_clear = 1'b1;
        send(5'd11, mk(12'h000, 11'h0AB, 9'h0CD));
        bus.cnt_clear = 1'b0;
        check("clear_wins", 64'(bus.cnt_local), 64'd0);
        tick();
        check_cnts();

        // Mid-stream reset with tag and other FIFOs partly filled.
        bus.tag_a = 1'b0;
        bus.other_a = 1'b0;
        bus.conf_report_tags = 1'b1;
        send(5'd11, mk(12'h000, 11'h0F0, 9'h00F));
        check("pre_rst_tag_v", 64'(bus.tag_v), 64'd1);
        check("pre_rst_other_v", 64'(bus.other_v), 64'd1);
        check("pre_rst_tag", 64'(bus.tag_tag), 64'h0F0);
        tick();
        check("hold_tag", 64'(bus.tag_tag), 64'h0F0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_tag_v", 64'(bus.tag_v), 64'd0);
        check("mid_rst_other_v", 64'(bus.other_v), 64'd0);
        check("mid_rst_gtag_v", 64'(bus.gtag_v), 64'd0);
        check("mid_rst_tag", 64'(bus.tag_tag), 64'd0);
        check("mid_rst_in_a", 64'(bus.in_a), 64'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        tick();
        bus.tag_a = 1'b1;
        bus.other_a = 1'b1;
        bus.conf_report_tags = 1'b0;
        send(5'd11, mk(12'h000, 11'h2AB, 9'h155));
        @(negedge clk);
        check("post_rst_tag_v", 64'(bus.tag_v), 64'd1);
        check("post_rst_tag", 64'({bus.tag_tag, bus.tag_ct}), 64'({11'h2AB, 9'h155}));
        check("post_rst_other_v", 64'(bus.other_v), 64'd0);
        repeat (4) tick();
        check_cnts();

        check("q_t_empty", 64'(q_t.size()), 64'd0);
        check("q_g_empty", 64'(q_g.size()), 64'd0);
        check("q_o_empty", 64'(q_o.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
